// File: rtl/word_packer_32to64.sv
// Packs pairs of 32-bit stream words into 64-bit words behind a valid/ready output register.
// Optional PACKER_PARITY_EN adds out_parity_o, the registered even parity of out_data_o.
module word_packer_32to64 #(
  parameter bit          LOW_FIRST = 1'b1,
  parameter logic [31:0] PAD_VALUE = 32'h0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_data_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [63:0]      out_data_o,
  output logic             out_partial_o,
`ifdef PACKER_PARITY_EN
  output logic             out_parity_o,
`endif
  output logic [CNT_W-1:0] out_count_o
);

  typedef enum logic [0:0] {StEmpty, StHalf} state_e;

  state_e             state_q, state_d;
  logic [31:0]        half_q, half_d;
  logic               out_valid_q, out_valid_d;
  logic [63:0]        out_data_q, out_data_d;
  logic               out_partial_q, out_partial_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic slot_free, in_fire, out_fire;

  assign slot_free  = !out_valid_q || out_ready_i;
  assign in_ready_o = (state_q == StEmpty) || slot_free;
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_fire   = out_valid_q && out_ready_i;

  always_comb begin
    state_d       = state_q;
    half_d        = half_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_partial_d = out_partial_q;
    count_d       = count_q + CNT_W'(out_fire);

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          half_d  = in_data_i;
          state_d = StHalf;
        end
      end
      StHalf: begin
        // A new input word always wins over flush in the same cycle.
        if (in_fire) begin
          out_data_d    = LOW_FIRST ? {in_data_i, half_q} : {half_q, in_data_i};
          out_valid_d   = 1'b1;
          out_partial_d = 1'b0;
          state_d       = StEmpty;
        end else if (flush_i && slot_free) begin
          out_data_d    = LOW_FIRST ? {PAD_VALUE, half_q} : {half_q, PAD_VALUE};
          out_valid_d   = 1'b1;
          out_partial_d = 1'b1;
          state_d       = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StEmpty;
      half_q        <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_partial_q <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      half_q        <= half_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_partial_q <= out_partial_d;
      count_q       <= count_d;
    end
  end

`ifdef PACKER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^out_data_d;
    end
  end

  assign out_parity_o = parity_q;
`endif

  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_partial_o = out_partial_q;
  assign out_count_o   = count_q;

endmodule
